vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 25 ++
 rtl/sync_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster types, default 640x480@60 timing and derived totals.
package vga_pkg;

  typedef logic [9:0] pixel_coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // True when lo <= v < hi; 11-bit compare so hi may reach 1024.
  function automatic logic in_range(pixel_coord_t v, int unsigned lo, int unsigned hi);
    return ({1'b0, v} >= 11'(lo)) && ({1'b0, v} < 11'(hi));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of DEPTH stages, each loaded with rst_val on reset.
module sync_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= rst_val;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters and sync/active decodes.
// Optional VGA_SYNC_DELAY_EN delays hsync/vsync/video_active by SYNC_DELAY pixel ticks.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic         CLK_50,
  input  logic         reset,
  output pixel_coord_t pixel_x,
  output pixel_coord_t pixel_y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_active,
  output logic         pixel_ce,
  output logic         frame_end
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned DIV_W    = 2;

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..4");
  end
  if (SYNC_DELAY > 16) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..16");
  end

  logic [DIV_W-1:0] div_cnt;
  pixel_coord_t     h_cnt, v_cnt;
  pixel_coord_t     h_nxt, v_nxt;
  logic             hs_nxt, vs_nxt, va_nxt;
  logic             hs_r, vs_r, va_r;
  logic             ce;

  assign ce = (div_cnt == DIV_W'(CLK_DIV - 1)) && !reset;

  // Next coordinates; decodes use them so sync/active line up with pixel_x/pixel_y.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (reset) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (ce) begin
      if (h_cnt == 10'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
    hs_nxt = !in_range(h_nxt, HS_START, HS_START + H_SYNC);
    vs_nxt = !in_range(v_nxt, VS_START, VS_START + V_SYNC);
    va_nxt = in_range(h_nxt, 0, H_VISIBLE) && in_range(v_nxt, 0, V_VISIBLE);
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      va_r    <= 1'b1;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      hs_r    <= hs_nxt;
      vs_r    <= vs_nxt;
      va_r    <= va_nxt;
    end
  end

  assign pixel_x   = h_cnt;
  assign pixel_y   = v_cnt;
  assign pixel_ce  = ce;
  assign frame_end = ce && (h_cnt == 10'(H_TOTAL - 1)) && (v_cnt == 10'(V_TOTAL - 1));

`ifdef VGA_SYNC_DELAY_EN
  // Align sync/active with the registered latency of downstream drawing objects.
  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk     (CLK_50),
    .reset   (reset),
    .en      (ce),
    .rst_val (3'b110),
    .d       ({hs_r, vs_r, va_r}),
    .q       ({hsync, vsync, video_active})
  );
`else
  assign hsync        = hs_r;
  assign vsync        = vs_r;
  assign video_active = va_r;
`endif

endmodule
